// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS memory port: access sizes, arbiter states, owners.
package mips_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        DONE  = 3'd2,
        ERR   = 3'd3,
        ABORT = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store data and misalignment detect.
module lane_align
    import mips_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic        misalign_c
);

    always_comb begin
        be_c       = 4'b0000;
        wdata_c    = wdata;
        misalign_c = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata[15:0]}};
                misalign_c = addr_lo[0];
            end
            SZ_WORD: begin
                be_c       = 4'b1111;
                misalign_c = (addr_lo != 2'b00);
            end
            default: misalign_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with latched transactions, access checking and a bounded wait for mem_ready.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = 8;

    arb_state_t       state;
    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] cnt;

    logic        pick_d_c;
    size_t       sel_size_c;
    logic [1:0]  sel_lo_c;
    logic [31:0] sel_addr_c;
    logic [31:0] sel_wdata_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misalign_c;

    // Data wins only when alone or when fetch was served last.
    always_comb begin
        pick_d_c    = d_req && (!if_req || last_owner == OWN_IF);
        sel_size_c  = pick_d_c ? size_t'(d_size) : SZ_WORD;
        sel_lo_c    = pick_d_c ? d_addr[1:0] : 2'b00;
        sel_addr_c  = pick_d_c ? d_addr : if_addr;
        sel_wdata_c = pick_d_c ? d_wdata : 32'h0;
    end

    lane_align u_lane_align (
        .size       (sel_size_c),
        .addr_lo    (sel_lo_c),
        .wdata      (sel_wdata_c),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .misalign_c (misalign_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            last_owner  <= OWN_D;
            cnt         <= '0;
            if_gnt      <= 1'b0;
            if_rdata    <= 32'h0;
            if_done     <= 1'b0;
            if_err      <= 1'b0;
            d_gnt       <= 1'b0;
            d_rdata     <= 32'h0;
            d_done      <= 1'b0;
            d_err       <= 1'b0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            timeout_err <= 1'b0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner     <= pick_d_c ? OWN_D : OWN_IF;
                        mem_addr  <= sel_addr_c & ~32'h3;
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                        cnt       <= '0;
                        if (pick_d_c && misalign_c) begin
                            state  <= ERR;
                            mem_we <= 1'b0;
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end else begin
                            state      <= BUSY;
                            mem_valid  <= 1'b1;
                            mem_we     <= pick_d_c && d_we;
                            last_owner <= pick_d_c ? OWN_D : OWN_IF;
                            if_gnt     <= !pick_d_c;
                            d_gnt      <= pick_d_c;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            if (!mem_we) d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state       <= ABORT;
                        mem_valid   <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                        if_gnt      <= 1'b0;
                        d_gnt       <= 1'b0;
                        if (owner == OWN_IF) begin
                            if_done <= 1'b1;
                            if_err  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    if_gnt <= 1'b0;
                    d_gnt  <= 1'b0;
                end
                ERR, ABORT: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule
